// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM-stage port of the pipelined core: word RAM,
// a four-register MMIO window and sticky illegal-store reporting. Reads are combinational.
module data_mem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] addr_i32,
    input  logic [31:0] wdata_i32,
    input  logic        we_i,
    output logic [31:0] rdata_o32,
    input  logic [31:0] dbg_addr_i32,
    output logic [31:0] dbg_rdata_o32,
    output logic        done_o,
    output logic [31:0] tohost_o32,
    output logic        err_o,
    output logic [1:0]  err_code_o2
);
    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    localparam logic [1:0] ERR_MISALIGNED = 2'b01;
    localparam logic [1:0] ERR_UNMAPPED   = 2'b10;
    localparam logic [1:0] ERR_READ_ONLY  = 2'b11;

    logic [31:0] mem_q [DEPTH_WORDS];

    logic [31:0] cycle_q, cycle_d;
    logic [31:0] stores_q, stores_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] scratch_q, scratch_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic [31:0]   mmio_off;
    logic          in_ram, in_mmio, misaligned;
    logic [1:0]    mmio_sel;
    logic [AW-1:0] ram_idx, dbg_idx;
    logic          dbg_in_ram;
    logic          ram_we, accept;

    assign mmio_off   = addr_i32 - MMIO_BASE;
    assign in_ram     = addr_i32 < RAM_BYTES;
    assign in_mmio    = mmio_off < 32'd16;
    assign mmio_sel   = mmio_off[3:2];
    assign misaligned = addr_i32[1:0] != 2'b00;
    assign ram_idx    = addr_i32[2 +: AW];
    assign dbg_in_ram = dbg_addr_i32 < RAM_BYTES;
    assign dbg_idx    = dbg_addr_i32[2 +: AW];

    // Only TOHOST (10) and SCRATCH (11) are writable in the MMIO window.
    assign accept = we_i && !misaligned && (in_ram || (in_mmio && mmio_sel[1]));
    assign ram_we = reset_i && we_i && !misaligned && in_ram;

    always_comb begin
        rdata_o32 = 32'h0;
        if (in_ram) begin
            rdata_o32 = mem_q[ram_idx];
        end else if (in_mmio) begin
            case (mmio_sel)
                2'd0:    rdata_o32 = cycle_q;
                2'd1:    rdata_o32 = stores_q;
                2'd2:    rdata_o32 = tohost_q;
                default: rdata_o32 = scratch_q;
            endcase
        end
    end

    always_comb begin
        dbg_rdata_o32 = 32'h0;
        if (dbg_in_ram) begin
            dbg_rdata_o32 = mem_q[dbg_idx];
        end
    end

    always_comb begin
        cycle_d    = cycle_q + 32'd1;
        stores_d   = stores_q + {31'd0, accept};
        tohost_d   = tohost_q;
        scratch_d  = scratch_q;
        done_d     = done_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (we_i) begin
            if (misaligned) begin
                err_d      = 1'b1;
                err_code_d = ERR_MISALIGNED;
            end else if (in_ram) begin
                err_d = err_q;
            end else if (in_mmio) begin
                case (mmio_sel)
                    2'd2: begin
                        tohost_d = wdata_i32;
                        done_d   = 1'b1;
                    end
                    2'd3:    scratch_d = wdata_i32;
                    default: begin
                        err_d      = 1'b1;
                        err_code_d = ERR_READ_ONLY;
                    end
                endcase
            end else begin
                err_d      = 1'b1;
                err_code_d = ERR_UNMAPPED;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cycle_q    <= 32'h0;
            stores_q   <= 32'h0;
            tohost_q   <= 32'h0;
            scratch_q  <= 32'h0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            cycle_q    <= cycle_d;
            stores_q   <= stores_d;
            tohost_q   <= tohost_d;
            scratch_q  <= scratch_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // RAM contents survive reset; the reset level only blocks writes.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            mem_q[ram_idx] <= wdata_i32;
        end
    end

    assign done_o      = done_q;
    assign tohost_o32  = tohost_q;
    assign err_o       = err_q;
    assign err_code_o2 = err_code_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed stimulus, an address-map model checked on
// every falling edge, and literal expectations at key points.
module tb_data_mem_responder;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] addr, wdata, dbg_addr;
    logic        we;
    logic [31:0] rdata, dbg_rdata, tohost;
    logic        done, err;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .MMIO_BASE(BASE)) dut (
        .clk_i(clk), .reset_i(reset_i), .addr_i32(addr), .wdata_i32(wdata), .we_i(we),
        .rdata_o32(rdata), .dbg_addr_i32(dbg_addr), .dbg_rdata_o32(dbg_rdata),
        .done_o(done), .tohost_o32(tohost), .err_o(err), .err_code_o2(err_code)
    );

    always #5 clk = ~clk;

    // Model state
    logic [31:0] m_ram [DEPTH];
    bit          m_ram_ok [DEPTH];
    logic [31:0] m_cycle, m_stores, m_tohost, m_scratch;
    logic        m_done, m_err;
    logic [1:0]  m_code;

    initial begin
        for (int i = 0; i < DEPTH; i++) m_ram_ok[i] = 1'b0;
    end

    function automatic bit in_window(input logic [31:0] a);
        return (a >= BASE) && (a <= BASE + 32'd15);
    endfunction

    always @(posedge clk or negedge reset_i) begin
        if (!reset_i) begin
            m_cycle = 0; m_stores = 0; m_tohost = 0; m_scratch = 0;
            m_done = 0; m_err = 0; m_code = 2'b00;
        end else begin
            if (we) begin
                if (addr % 4 != 0) begin
                    m_err = 1; m_code = 2'b01;
                end else if (addr < DEPTH * 4) begin
                    m_ram[addr / 4] = wdata; m_ram_ok[addr / 4] = 1'b1;
                    m_stores = m_stores + 1;
                end else if (in_window(addr)) begin
                    case ((addr - BASE) / 4)
                        2: begin m_tohost = wdata; m_done = 1; m_stores = m_stores + 1; end
                        3: begin m_scratch = wdata; m_stores = m_stores + 1; end
                        default: begin m_err = 1; m_code = 2'b11; end
                    endcase
                end else begin
                    m_err = 1; m_code = 2'b10;
                end
            end
            m_cycle = m_cycle + 1;
        end
    end

    task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
        known = 1'b1;
        v     = 32'h0;
        if (a < DEPTH * 4) begin
            known = m_ram_ok[a / 4];
            v     = m_ram[a / 4];
        end else if (in_window(a)) begin
            case ((a - BASE) / 4)
                0: v = m_cycle;
                1: v = m_stores;
                2: v = m_tohost;
                default: v = m_scratch;
            endcase
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic [31:0] ev;
        bit          ek;
        model_read(addr, ev, ek);
        if (ek) chk("rdata", rdata, ev);
        if (dbg_addr >= DEPTH * 4) chk("dbg_oor", dbg_rdata, 32'h0);
        else if (m_ram_ok[dbg_addr / 4]) chk("dbg_rdata", dbg_rdata, m_ram[dbg_addr / 4]);
        chk("done", {31'd0, done}, {31'd0, m_done});
        chk("tohost", tohost, m_tohost);
        chk("err", {31'd0, err}, {31'd0, m_err});
        chk("err_code", {30'd0, err_code}, {30'd0, m_code});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic look(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, rdata, exp);
    endtask

    initial begin
        reset_i = 1'b0; we = 1'b0; addr = 32'h0; wdata = 32'h0; dbg_addr = 32'h10;
        #2;
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_code", {30'd0, err_code}, 32'd0);
        chk("reset_tohost", tohost, 32'h0);
        #10 reset_i = 1'b1;
        store(32'h10, 32'h1111_1111);
        reset_i = 1'b0; #2; reset_i = 1'b1;

        // 1: same-cycle old value, new value after the edge
        addr = 32'h10; wdata = 32'hDEAD_BEEF; we = 1'b1;
        #1;
        chk("t1_old", rdata, 32'h1111_1111);
        step();
        we = 1'b0;
        #1;
        chk("t1_new", rdata, 32'hDEAD_BEEF);
        chk("t1_dbg", dbg_rdata, 32'hDEAD_BEEF);
        look("t1_stores", BASE + 32'h4, 32'd1);

        // 2: CYCLE count and wrap
        reset_i = 1'b0; #1; reset_i = 1'b1;
        look("t2_cyc0", BASE, 32'd0);
        repeat (10) step();
        look("t2_cyc10", BASE, 32'd10);
        dut.cycle_q = 32'hFFFF_FFFF;
        m_cycle     = 32'hFFFF_FFFF;
        look("t2_cycmax", BASE, 32'hFFFF_FFFF);
        step();
        look("t2_wrap", BASE, 32'd0);

        // 3: TOHOST / done
        addr = BASE + 32'h8; wdata = 32'd5; we = 1'b1;
        #1;
        chk("t3_done_pre", {31'd0, done}, 32'd0);
        step();
        we = 1'b0;
        #1;
        chk("t3_done", {31'd0, done}, 32'd1);
        chk("t3_tohost5", tohost, 32'd5);
        store(BASE + 32'h8, 32'd7);
        #1;
        chk("t3_tohost7", tohost, 32'd7);
        chk("t3_done_hold", {31'd0, done}, 32'd1);
        look("t3_tohost_rd", BASE + 32'h8, 32'd7);
        store(BASE + 32'hC, 32'h5C5C_0001);
        look("t3_scratch", BASE + 32'hC, 32'h5C5C_0001);

        // 4: illegal stores
        store(32'h12, 32'h1234_5678);
        look("t4_ram4", 32'h10, 32'hDEAD_BEEF);
        chk("t4_err", {31'd0, err}, 32'd1);
        chk("t4_code_mis", {30'd0, err_code}, 32'd1);
        look("t4_stores", BASE + 32'h4, 32'd3);
        store(BASE, 32'h0);
        #1;
        chk("t4_code_ro", {30'd0, err_code}, 32'd3);
        store(32'h400, 32'h0);
        #1;
        chk("t4_code_unm", {30'd0, err_code}, 32'd2);
        store(32'h20, 32'h2);
        #1;
        chk("t4_err_sticky", {31'd0, err}, 32'd1);

        // 5: unmapped reads, ignored low address bits
        reset_i = 1'b0; #1; reset_i = 1'b1;
        addr = 32'h1000;
        repeat (3) step();
        chk("t5_unmapped", rdata, 32'h0);
        chk("t5_no_err", {31'd0, err}, 32'd0);
        store(32'h10, 32'hA5A5_A5A5);
        look("t5_low_bits", 32'h13, 32'hA5A5_A5A5);

        // 6: asynchronous reset mid-operation
        store(32'h20, 32'h0000_0C0C);
        store(BASE + 32'h8, 32'h1);
        store(32'h21, 32'h3);
        look("t6_stores3", BASE + 32'h4, 32'd3);
        chk("t6_done1", {31'd0, done}, 32'd1);
        chk("t6_err1", {31'd0, err}, 32'd1);
        #1;
        reset_i = 1'b0;
        #1;
        chk("t6_done_clr", {31'd0, done}, 32'd0);
        chk("t6_err_clr", {31'd0, err}, 32'd0);
        chk("t6_stores_clr", rdata, 32'd0);
        addr = 32'h20; wdata = 32'hBAD0_BAD0; we = 1'b1;
        repeat (2) step();
        we = 1'b0;
        reset_i = 1'b1;
        look("t6_ram_kept", 32'h20, 32'h0000_0C0C);
        look("t6_stores0", BASE + 32'h4, 32'd0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t limit 100000", $time);
        $fatal(1);
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder on the far side of the pipelined MIPS core's MEM-stage port.
- Accepts the core's word address, store data and store enable.
- Returns read data combinationally, so the core can capture it in its MEM->WB register in the same cycle.
- Adds a small MMIO window with a cycle counter, a store counter, a tohost/done register and a scratch register, plus sticky error reporting for illegal stores.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; power of two, at least 2.
- MMIO_BASE, 32'hFFFF_0000, base byte address of the 4-register MMIO window.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- addr_i32  in  32  byte address (core ALU output, MEM stage).
- wdata_i32  in  32  store data.
- we_i  in  1  store enable, sampled at rising edge.
- rdata_o32  out  32  combinational read data for addr_i32.
- dbg_addr_i32  in  32  bench/debug read address, RAM region only.
- dbg_rdata_o32  out  32  combinational RAM read for dbg_addr_i32; 0 if out of range.
- done_o  out  1  sticky; set by any accepted store to TOHOST.
- tohost_o32  out  32  last value stored to TOHOST.
- err_o  out  1  sticky illegal-store flag.
- err_code_o2  out  2  cause of the most recent illegal store: 01 misaligned, 10 unmapped, 11 read-only.

Behaviour:
- Address map (byte addresses):
  - RAM: [0, DEPTH_WORDS*4); word index = addr[2 +: log2(DEPTH_WORDS)].
  - MMIO_BASE+0x0 CYCLE (read-only)
  - MMIO_BASE+0x4 STORES (read-only)
  - MMIO_BASE+0x8 TOHOST (read/write)
  - MMIO_BASE+0xC SCRATCH (read/write)
  - Anything else is unmapped.
- Reads:
  - Purely combinational, zero latency, every cycle, no read enable.
  - addr[1:0] is ignored for reads.
  - Unmapped reads return 32'h0.
  - Reads never set err_o; the core drives addr_i32 every cycle, including for non-memory instructions.
- Stores, decided at the rising edge when we_i=1:
  - If addr[1:0]!=0: store is dropped; err_o<=1; err_code<=01.
  - Else if the address is in RAM, TOHOST or SCRATCH: store is accepted and the target is written.
  - Else if the address is CYCLE or STORES: store is dropped; err_o<=1; err_code<=11.
  - Else (unmapped): store is dropped; err_o<=1; err_code<=10.
  - Misaligned takes priority over all other causes.
- Write/read ordering:
  - A read of the address being stored in the same cycle returns the old value.
  - The new value is visible from the cycle after the edge.
- CYCLE:
  - 0 out of reset; +1 every clock edge while reset_i=1.
  - Wraps 32'hFFFF_FFFF -> 0.
- STORES:
  - 0 out of reset; +1 on every accepted store (RAM or MMIO); dropped stores do not count.
  - Wraps at 2^32.
  - A read in the cycle of a store returns the pre-increment value.
- TOHOST:
  - An accepted store updates tohost_o32 and sets done_o at that edge, so done_o is visible the cycle after the store.
  - done_o stays 1 until reset; later stores update tohost_o32 only.
- err_o:
  - Sticky until reset.
  - err_code_o2 is overwritten by each new illegal store.
  - err_o stays 1 after a later legal store.
- Reset values:
  - CYCLE=0, STORES=0, tohost_o32=0, SCRATCH=0, done_o=0, err_o=0, err_code_o2=00.
  - RAM contents are not reset (undefined until written).
- Reset mid-operation:
  - Assertion clears all registers immediately, without waiting for a clock.
  - A store coinciding with the reset edge or occurring during reset is discarded and not counted.
  - After deassertion, CYCLE reads 0 until the first edge.
- dbg port: read-only; never affects state or errors.

Test Plan:
1. Reset, then store 32'hDEAD_BEEF to 0x10; same-cycle rdata_o32 shows the old value; next cycle rdata_o32=32'hDEAD_BEEF, dbg_rdata_o32(0x10)=32'hDEAD_BEEF, STORES reads 1.
2. Release reset and hold 10 cycles without stores -> CYCLE reads 10. Force CYCLE to 32'hFFFF_FFFF via a back-door hierarchical deposit in the bench -> reads 0 after the next edge.
3. Store 0x0000_0005 to MMIO_BASE+0x8 -> done_o=1 the next cycle and tohost_o32=5. A second store of 7 -> tohost_o32=7, done_o stays 1.
4. Illegal stores:
   - Store to 0x12 (misaligned) -> err_o=1, err_code_o2=01, RAM word 4 unchanged, STORES unchanged.
   - Then store to MMIO_BASE+0x0 -> err_code_o2=11.
   - Then store to 0x400 with DEPTH_WORDS=64 -> err_code_o2=10.
5. Read 0x1000 (unmapped) with we_i=0 for 3 cycles -> rdata_o32=0, err_o remains 0. Read 0x13 after storing 32'hA5A5_A5A5 to 0x10 -> rdata_o32=32'hA5A5_A5A5.
6. Assert reset_i=0 between edges while done_o=1, err_o=1 and STORES=3 -> all three clear immediately. Hold we_i=1 during reset -> no RAM write and STORES stays 0 after release.
